act_streamer: RTL and testbench
===============================

ACT_STREAMER -- requirements
Module: act_streamer

Interface
REQ-001 SHALL have parameter H, default 24, spatial positions per frame.
REQ-002 SHALL have parameter K, default 8, channels per position.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, activation byte width.
REQ-004 SHALL have parameter RELU, default 1; 1 clamps negative activations to 0, 0 passes them through.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous and active-high, despite the name.
REQ-007 SHALL have port act_i, input, H*K*DATA_WIDTH, [0:MSB-first] frame from the adder stage; byte (c,h) at offset (c*H+h)*DATA_WIDTH.
REQ-008 SHALL have port done_add_i, input, 1, single-cycle frame-valid strobe.
REQ-009 SHALL have port stream_data_o, output, K*DATA_WIDTH, channels 0..K-1 of one position, channel 0 in the most significant byte.
REQ-010 SHALL have port stream_valid_o, output, 1, stream beat valid.
REQ-011 SHALL have port stream_ready_i, input, 1, downstream accepts the beat.
REQ-012 SHALL have port stream_last_o, output, 1, marks position H-1.
REQ-013 SHALL have port busy_o, output, 1, high while in SEND.
REQ-014 SHALL have port done_stream_o, output, 1, one-cycle pulse after the final beat.
REQ-015 SHALL have port overflow_o, output, 1, sticky; a frame was dropped.

Function
REQ-016 SHALL implement FSM IDLE/SEND; reset state IDLE.
REQ-017 SHALL, in IDLE with done_add_i=1, capture act_i into a frame buffer, set position counter pos=0 and enter SEND on the next edge.
REQ-018 SHALL assert stream_valid_o exactly when in SEND; first beat valid one cycle after the done_add_i strobe.
REQ-019 SHALL drive stream_data_o byte c = buffer byte (c,pos), passed through ReLU when RELU=1 (signed compare, negative -> 0).
REQ-020 SHALL hold stream_data_o, stream_last_o and pos stable while stream_valid_o=1 and stream_ready_i=0.
REQ-021 SHALL increment pos on each transfer (valid & ready); stream_last_o = SEND & (pos==H-1).
REQ-022 SHALL, on the transfer with pos==H-1, pulse done_stream_o for the following cycle and return to IDLE, pos=0.
REQ-023 SHALL, when done_add_i coincides with the final transfer, capture the new frame and remain in SEND with pos=0 (back-to-back, no idle cycle; done_stream_o still pulses).
REQ-024 SHALL ignore done_add_i in SEND on any non-final cycle, leave the buffer unchanged and set overflow_o=1 until reset.
REQ-025 SHALL size pos to $clog2(H) bits and never exceed H-1.
REQ-026 SHALL ignore stream_ready_i outside SEND.

Reset
REQ-027 SHALL, on rst_n high at any time (including mid-frame), force IDLE, pos=0, buffer=0, stream_valid_o=0, stream_last_o=0, busy_o=0, done_stream_o=0, overflow_o=0, stream_data_o=0.
REQ-028 SHALL treat a done_add_i strobe in the first cycle after reset release as a valid frame.

Structure
REQ-029 SHALL take H, K and DATA_WIDTH defaults from the shared layer-parameter package used by the adder stage.
REQ-030 SHALL instantiate one sub-module, act_relu, a K-lane combinational signed clamp selected by RELU.

Verification
REQ-031 SHALL cover: act_i byte (c,h)=c*16+h, done strobe, ready=1 -> 24 beats on consecutive cycles; beat 0 = 0x00,0x10..0x70; last on beat 23; done_stream_o one cycle later.
REQ-032 SHALL cover: all bytes 0x80 (-128), RELU=1 -> every beat 0; RELU=0 -> every byte 0x80.
REQ-033 SHALL cover: ready toggling 1,0,0,1 -> data and pos held during low cycles; exactly 24 transfers.
REQ-034 SHALL cover: second done at beat 5 -> overflow_o=1 and frame 1 completes unchanged; a second done coinciding with beat 23 -> frame 2 starts next cycle at pos 0, overflow_o stays 0.
REQ-035 SHALL cover: rst_n asserted at beat 10 -> valid low the same cycle, all outputs 0; a fresh frame afterwards streams from pos 0.

Source files
------------

// File: rtl/act_streamer_pkg.sv
// Shared layer parameters and streamer types. The adder stage and the activation
// streamer both take their frame geometry from here, so the two stages always agree.
package act_streamer_pkg;

  localparam int LAYER_H          = 24;
  localparam int LAYER_K          = 8;
  localparam int LAYER_DATA_WIDTH = 8;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } stream_state_e;

  // Position counter width; a one-position frame still needs a one-bit counter.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/act_streamer_if.sv
// Activation beat stream: one spatial position (K channels) per beat with a valid/ready handshake.
interface act_streamer_if
  import act_streamer_pkg::*;
#(
  parameter int K          = LAYER_K,
  parameter int DATA_WIDTH = LAYER_DATA_WIDTH
) ();

  logic [K*DATA_WIDTH-1:0] stream_data_o;
  logic                    stream_valid_o;
  logic                    stream_ready_i;
  logic                    stream_last_o;

  modport master (
    output stream_data_o,
    output stream_valid_o,
    output stream_last_o,
    input  stream_ready_i
  );

  modport slave (
    input  stream_data_o,
    input  stream_valid_o,
    input  stream_last_o,
    output stream_ready_i
  );

endinterface

// File: rtl/act_relu.sv
// K-lane combinational ReLU: each signed lane is clamped to zero when negative, or passed
// through untouched when RELU is 0.
module act_relu
  import act_streamer_pkg::*;
#(
  parameter int K          = LAYER_K,
  parameter int DATA_WIDTH = LAYER_DATA_WIDTH,
  parameter int RELU       = 1
) (
  input  logic [K*DATA_WIDTH-1:0] din,
  output logic [K*DATA_WIDTH-1:0] dout
);

  always_comb begin
    // NOTE: dout gets a full default before the per-lane overrides so no path leaves it unassigned (no latch).
    dout = din;
    if (RELU != 0) begin
      for (int c = 0; c < K; c++) begin
        // The lane's sign bit set means the signed value is below zero.
        if (din[c*DATA_WIDTH + DATA_WIDTH - 1]) begin
          dout[c*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

endmodule

// File: rtl/act_streamer.sv
// Activation streamer: captures a full H x K frame from the adder stage and streams it out
// one position per beat (channels 0..K-1), with optional ReLU and back-to-back frame support.
module act_streamer
  import act_streamer_pkg::*;
#(
  parameter int H          = LAYER_H,
  parameter int K          = LAYER_K,
  parameter int DATA_WIDTH = LAYER_DATA_WIDTH,
  parameter int RELU       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [H*K*DATA_WIDTH-1:0] act_i,
  input  logic                      done_add_i,
  act_streamer_if.master            strm,
  output logic                      busy_o,
  output logic                      done_stream_o,
  output logic                      overflow_o
);

  localparam int FRAME_W = H * K * DATA_WIDTH;
  localparam int BEAT_W  = K * DATA_WIDTH;
  localparam int POS_W   = pos_width(H);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(H - 1);

  stream_state_e     state;
  logic [POS_W-1:0]  pos;
  logic [BEAT_W-1:0] frame      [H];
  logic [BEAT_W-1:0] act_beats  [H];
  logic [BEAT_W-1:0] beat_out;
  logic              xfer;
  logic              final_xfer;
  logic              accept;

  // The adder packs bytes channel-major from the MSB; regroup them per position so a
  // beat is a single buffer word with channel 0 in its most significant byte.
  always_comb begin
    act_beats = '{default: '0};
    for (int h = 0; h < H; h++) begin
      for (int c = 0; c < K; c++) begin
        act_beats[h][(K-1-c)*DATA_WIDTH +: DATA_WIDTH] =
          act_i[FRAME_W - 1 - (c*H + h)*DATA_WIDTH -: DATA_WIDTH];
      end
    end
  end

  assign xfer       = (state == ST_SEND) && strm.stream_ready_i;
  assign final_xfer = xfer && (pos == LAST_POS);
  // A new frame is only taken when the buffer is free now or frees on this very edge.
  assign accept     = done_add_i && ((state == ST_IDLE) || final_xfer);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= ST_IDLE;
      pos           <= '0;
      done_stream_o <= 1'b0;
      overflow_o    <= 1'b0;
      // NOTE: the frame buffer is reset too, so the beat data reads as zero straight out of reset.
      for (int h = 0; h < H; h++) frame[h] <= '0;
    end else begin
      done_stream_o <= final_xfer;
      if (done_add_i && !accept) overflow_o <= 1'b1;
      if (accept) begin
        for (int h = 0; h < H; h++) frame[h] <= act_beats[h];
      end
      unique case (state)
        ST_IDLE: begin
          if (done_add_i) begin
            state <= ST_SEND;
            pos   <= '0;
          end
        end
        ST_SEND: begin
          if (final_xfer) begin
            pos <= '0;
            if (!done_add_i) state <= ST_IDLE;
          end else if (xfer) begin
            pos <= pos + 1'b1;
          end
        end
      endcase
    end
  end

  act_relu #(
    .K          (K),
    .DATA_WIDTH (DATA_WIDTH),
    .RELU       (RELU)
  ) u_act_relu (
    .din  (frame[pos]),
    .dout (beat_out)
  );

  assign strm.stream_data_o  = beat_out;
  assign strm.stream_valid_o = (state == ST_SEND);
  assign strm.stream_last_o  = (state == ST_SEND) && (pos == LAST_POS);
  assign busy_o              = (state == ST_SEND);

endmodule

// File: tb/tb_act_streamer.sv
// Bench for act_streamer: a ReLU and a pass-through instance share all stimulus and are
// checked against a frame/beat-queue reference model of the streaming behaviour.
module tb_act_streamer;
  import act_streamer_pkg::*;

  localparam int H  = LAYER_H;
  localparam int K  = LAYER_K;
  localparam int DW = LAYER_DATA_WIDTH;
  localparam int W  = H * K * DW;
  localparam int BW = K * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  act_i = '0;
  logic          done_add_i = 1'b0;
  logic          ready = 1'b0;
  logic          busy_r, done_r, ovf_r;
  logic          busy_p, done_p, ovf_p;

  always #5 clk = ~clk;

  act_streamer_if #(.K(K), .DATA_WIDTH(DW)) s_r ();
  act_streamer_if #(.K(K), .DATA_WIDTH(DW)) s_p ();
  assign s_r.stream_ready_i = ready;
  assign s_p.stream_ready_i = ready;

  act_streamer #(.H(H), .K(K), .DATA_WIDTH(DW), .RELU(1)) dut_relu (
    .clk (clk), .rst_n (rst_n), .act_i (act_i), .done_add_i (done_add_i), .strm (s_r),
    .busy_o (busy_r), .done_stream_o (done_r), .overflow_o (ovf_r)
  );

  act_streamer #(.H(H), .K(K), .DATA_WIDTH(DW), .RELU(0)) dut_pass (
    .clk (clk), .rst_n (rst_n), .act_i (act_i), .done_add_i (done_add_i), .strm (s_p),
    .busy_o (busy_p), .done_stream_o (done_p), .overflow_o (ovf_p)
  );

  // Reference model: the frame being driven, beats still owed, expected beat words, sticky overflow.
  byte unsigned  fb [K][H];
  int            beats_left = 0;
  bit            ovf_m = 1'b0;
  logic [BW-1:0] exp_r [$];
  logic [BW-1:0] exp_p [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_xfer = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat(input int h, input bit relu);
    logic [BW-1:0] w;
    byte unsigned  b;
    w = '0;
    for (int c = 0; c < K; c++) begin
      b = fb[c][h];
      if (relu && b >= 8'h80) b = 8'h00;
      w[(K-1-c)*DW +: DW] = b;
    end
    return w;
  endfunction

  task automatic pack_frame();
    for (int c = 0; c < K; c++)
      for (int h = 0; h < H; h++)
        act_i[W - 1 - (c*H + h)*DW -: DW] = fb[c][h];
  endtask

  task automatic load_ramp();
    for (int c = 0; c < K; c++)
      for (int h = 0; h < H; h++) fb[c][h] = 8'(c*16 + h);
    pack_frame();
  endtask

  task automatic load_const(input byte unsigned v);
    for (int c = 0; c < K; c++)
      for (int h = 0; h < H; h++) fb[c][h] = v;
    pack_frame();
  endtask

  task automatic load_random();
    for (int c = 0; c < K; c++)
      for (int h = 0; h < H; h++) fb[c][h] = 8'($urandom_range(0, 255));
    pack_frame();
  endtask

  // One clock: check pre-edge outputs against the model, advance the model, clock, check pulses.
  task automatic cycle();
    bit xfer, nd, acc;
    check("valid_r", s_r.stream_valid_o, beats_left > 0);
    check("valid_p", s_p.stream_valid_o, beats_left > 0);
    check("busy_r", busy_r, beats_left > 0);
    check("last_r", s_r.stream_last_o, beats_left == 1);
    check("last_p", s_p.stream_last_o, beats_left == 1);
    if (beats_left > 0) begin
      check("data_r", s_r.stream_data_o, exp_r[0]);
      check("data_p", s_p.stream_data_o, exp_p[0]);
    end
    if (s_r.stream_valid_o && ready) n_xfer++;
    xfer = ready && (beats_left > 0);
    nd   = xfer && (beats_left == 1);
    acc  = done_add_i && ((beats_left == 0) || nd);
    if (xfer) begin
      void'(exp_r.pop_front());
      void'(exp_p.pop_front());
      beats_left--;
    end
    if (done_add_i && !acc) ovf_m = 1'b1;
    if (acc) begin
      for (int h = 0; h < H; h++) begin
        exp_r.push_back(beat(h, 1'b1));
        exp_p.push_back(beat(h, 1'b0));
      end
      beats_left = H;
    end
    @(posedge clk);
    #1;
    check("done_stream_r", done_r, nd);
    check("done_stream_p", done_p, nd);
    check("overflow_r", ovf_r, ovf_m);
    check("overflow_p", ovf_p, ovf_m);
  endtask

  task automatic strobe_frame();
    done_add_i = 1'b1;
    cycle();
    done_add_i = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    ready = 1'b1;
    for (int i = 0; i < budget && beats_left > 0; i++) cycle();
    check("idle_timeout", busy_r, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b1;
    #1;
    check({tag, "_valid"}, {s_r.stream_valid_o, s_p.stream_valid_o}, 2'b00);
    check({tag, "_last"}, {s_r.stream_last_o, s_p.stream_last_o}, 2'b00);
    check({tag, "_busy"}, {busy_r, busy_p}, 2'b00);
    check({tag, "_done"}, {done_r, done_p}, 2'b00);
    check({tag, "_ovf"}, {ovf_r, ovf_p}, 2'b00);
    check({tag, "_data_r"}, s_r.stream_data_o, 64'h0);
    check({tag, "_data_p"}, s_p.stream_data_o, 64'h0);
    beats_left = 0;
    ovf_m = 1'b0;
    exp_r.delete();
    exp_p.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  initial begin
    #2;
    reset_pulse("por");

    // Ramp frame strobed in the first cycle after reset release.
    load_ramp();
    ready = 1'b1;
    n_xfer = 0;
    strobe_frame();
    check("ramp_beat0_r", s_r.stream_data_o, 64'h0010203040506070);
    check("ramp_beat0_p", s_p.stream_data_o, 64'h0010203040506070);
    run_idle(60);
    check("ramp_xfers", n_xfer, 24);

    // All bytes -128.
    load_const(8'h80);
    strobe_frame();
    check("neg_beat0_r", s_r.stream_data_o, 64'h0);
    check("neg_beat0_p", s_p.stream_data_o, 64'h8080808080808080);
    run_idle(60);

    // Ready pattern 1,0,0,1 repeating.
    load_random();
    n_xfer = 0;
    strobe_frame();
    for (int i = 0; i < 200 && beats_left > 0; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    check("toggle_xfers", n_xfer, 24);
    run_idle(10);

    // Second strobe at beat 5 is dropped and flags overflow.
    load_random();
    ready = 1'b1;
    strobe_frame();
    repeat (5) cycle();
    load_random();
    strobe_frame();
    check("overflow_set", ovf_r, 1'b1);
    run_idle(60);

    // Reset at beat 10, then a fresh frame.
    load_random();
    strobe_frame();
    repeat (10) cycle();
    reset_pulse("mid_rst");
    load_random();
    strobe_frame();
    check("fresh_beat0_r", s_r.stream_data_o, beat(0, 1'b1));
    run_idle(60);

    // Strobe coinciding with the final transfer starts the next frame with no idle cycle.
    load_random();
    strobe_frame();
    repeat (H - 1) cycle();
    load_random();
    strobe_frame();
    check("b2b_valid", s_r.stream_valid_o, 1'b1);
    check("b2b_beat0_r", s_r.stream_data_o, beat(0, 1'b1));
    check("b2b_beat0_p", s_p.stream_data_o, beat(0, 1'b0));
    check("b2b_no_ovf", ovf_r, 1'b0);
    run_idle(60);

    // Random ready and random strobes.
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        load_random();
        done_add_i = 1'b1;
      end
      cycle();
      done_add_i = 1'b0;
    end
    run_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
